ysyx_23060025_line_wbuf: RTL and testbench

- Write-burst engine between the CPU data-write port and the AXI controller/xbar write channels.
- Accepts one write request at a time from the CPU/dcache: either a single store or a full cache-line writeback.
- Converts it into one AXI4 write transaction: AW phase, then N W beats, then the B response.
- Reports completion and error back to the CPU with a one-cycle pulse.

---
 rtl/ysyx_23060025_line_wbuf.sv | 153 +++++++++++++++
 tb/tb_ysyx_23060025_line_wbuf.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_line_wbuf.sv
// Write-burst engine: turns one CPU store or cache-line writeback into a single
// AXI4 write transaction (AW, then W beats, then B) and pulses done/err back.
module ysyx_23060025_line_wbuf #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int LINE_W   = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_valid_i,
  output logic                wb_ready_o,
  input  logic [ADDR_LEN-1:0] wb_addr_i,
  input  logic [LINE_W-1:0]   wb_data_i,
  input  logic [3:0]          wb_strb_i,
  input  logic [2:0]          wb_type_i,
  output logic                wb_done_o,
  output logic                wb_err_o,
  output logic [ADDR_LEN-1:0] axi_addr_w_addr_o,
  output logic                axi_addr_w_valid_o,
  input  logic                axi_addr_w_ready_i,
  output logic [7:0]          axi_addr_w_len_o,
  output logic [2:0]          axi_addr_w_size_o,
  output logic [DATA_LEN-1:0] axi_w_data_o,
  output logic [3:0]          axi_w_strb_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  output logic                axi_w_last_o,
  input  logic                axi_bkwd_valid_i,
  input  logic [1:0]          axi_bkwd_resp_i,
  output logic                axi_bkwd_ready_o
);

  localparam int BEATS = LINE_W / DATA_LEN;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [2:0]       TYPE_LINE = 3'd3;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t            state_p0, state_nxt;
  logic [LINE_W-1:0] line_p0;
  logic [CNT_W-1:0]  beat_p0, beat_nxt;

  logic accept, aw_hs, w_hs, w_last_hs, b_hs;

  assign accept    = (state_p0 == S_IDLE) && wb_valid_i;
  assign aw_hs     = axi_addr_w_valid_o && axi_addr_w_ready_i;
  assign w_hs      = axi_w_valid_o && axi_w_ready_i;
  assign w_last_hs = w_hs && axi_w_last_o;
  assign b_hs      = axi_bkwd_ready_o && axi_bkwd_valid_i;

  // Request decode: line writebacks are aligned and forced to full-strobe words;
  // types 4..7 fall through as word stores.
  logic                req_line;
  logic [ADDR_LEN-1:0] req_addr;
  logic [7:0]          req_len;
  logic [2:0]          req_size;
  logic [3:0]          req_strb;
  logic [LINE_W-1:0]   req_data;

  always_comb begin
    req_line = (wb_type_i == TYPE_LINE);
    req_addr = wb_addr_i;
    req_len  = 8'd0;
    req_size = (wb_type_i > 3'd2) ? 3'd2 : wb_type_i;
    req_strb = wb_strb_i;
    req_data = {{(LINE_W-DATA_LEN){1'b0}}, wb_data_i[DATA_LEN-1:0]};
    if (req_line) begin
      req_addr = {wb_addr_i[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
      req_len  = 8'(BEATS - 1);
      req_size = 3'b010;
      req_strb = 4'hF;
      req_data = wb_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_p0 <= S_IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_IDLE:  if (wb_valid_i) state_nxt = S_AW;
      S_AW:    if (aw_hs)      state_nxt = S_W;
      S_W:     if (w_last_hs)  state_nxt = S_B;
      S_B:     if (b_hs)       state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state so every
  // port comes straight out of a flop.
  logic                ready_nxt, awvalid_nxt, wvalid_nxt, wlast_nxt, bready_nxt;
  logic                done_nxt, err_nxt;
  logic [DATA_LEN-1:0] wdata_nxt;

  always_comb begin
    ready_nxt   = (state_nxt == S_IDLE);
    awvalid_nxt = (state_nxt == S_AW);
    wvalid_nxt  = (state_nxt == S_W);
    bready_nxt  = (state_nxt == S_B);
    done_nxt    = b_hs;
    err_nxt     = b_hs && (axi_bkwd_resp_i != 2'b00);

    beat_nxt = beat_p0;
    if (accept)    beat_nxt = '0;
    else if (w_hs) beat_nxt = axi_w_last_o ? '0 : beat_p0 + CNT_ONE;

    wlast_nxt = wvalid_nxt && (8'(beat_nxt) == axi_addr_w_len_o);
    wdata_nxt = wvalid_nxt ? line_p0[beat_nxt*DATA_LEN +: DATA_LEN] : axi_w_data_o;
  end

  // Registered outputs and the latched request
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_ready_o         <= 1'b1;
      wb_done_o          <= 1'b0;
      wb_err_o           <= 1'b0;
      axi_addr_w_valid_o <= 1'b0;
      axi_w_valid_o      <= 1'b0;
      axi_w_last_o       <= 1'b0;
      axi_bkwd_ready_o   <= 1'b0;
      axi_addr_w_addr_o  <= '0;
      axi_addr_w_len_o   <= '0;
      axi_addr_w_size_o  <= '0;
      axi_w_data_o       <= '0;
      axi_w_strb_o       <= '0;
      line_p0            <= '0;
      beat_p0            <= '0;
    end else begin
      wb_ready_o         <= ready_nxt;
      wb_done_o          <= done_nxt;
      wb_err_o           <= err_nxt;
      axi_addr_w_valid_o <= awvalid_nxt;
      axi_w_valid_o      <= wvalid_nxt;
      axi_w_last_o       <= wlast_nxt;
      axi_bkwd_ready_o   <= bready_nxt;
      axi_w_data_o       <= wdata_nxt;
      beat_p0            <= beat_nxt;
      if (accept) begin
        axi_addr_w_addr_o <= req_addr;
        axi_addr_w_len_o  <= req_len;
        axi_addr_w_size_o <= req_size;
        axi_w_strb_o      <= req_strb;
        line_p0           <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_line_wbuf.sv
// Scoreboard bench for the line write-burst engine: stimulus pushes expected
// AW/W/B outcomes, a negedge monitor pops and compares them.
module tb_ysyx_23060025_line_wbuf;

  localparam int BEATS      = 4;
  localparam int LINE_BYTES = 16;

  logic         clock, reset;
  logic         wb_valid_i, wb_ready_o;
  logic [31:0]  wb_addr_i;
  logic [127:0] wb_data_i;
  logic [3:0]   wb_strb_i;
  logic [2:0]   wb_type_i;
  logic         wb_done_o, wb_err_o;
  logic [31:0]  axi_addr_w_addr_o;
  logic         axi_addr_w_valid_o, axi_addr_w_ready_i;
  logic [7:0]   axi_addr_w_len_o;
  logic [2:0]   axi_addr_w_size_o;
  logic [31:0]  axi_w_data_o;
  logic [3:0]   axi_w_strb_o;
  logic         axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
  logic         axi_bkwd_valid_i, axi_bkwd_ready_o;
  logic [1:0]   axi_bkwd_resp_i;

  ysyx_23060025_line_wbuf dut (
    .clock(clock), .reset(reset),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .wb_strb_i(wb_strb_i), .wb_type_i(wb_type_i),
    .wb_done_o(wb_done_o), .wb_err_o(wb_err_o),
    .axi_addr_w_addr_o(axi_addr_w_addr_o), .axi_addr_w_valid_o(axi_addr_w_valid_o),
    .axi_addr_w_ready_i(axi_addr_w_ready_i), .axi_addr_w_len_o(axi_addr_w_len_o),
    .axi_addr_w_size_o(axi_addr_w_size_o), .axi_w_data_o(axi_w_data_o),
    .axi_w_strb_o(axi_w_strb_o), .axi_w_valid_o(axi_w_valid_o),
    .axi_w_ready_i(axi_w_ready_i), .axi_w_last_o(axi_w_last_o),
    .axi_bkwd_valid_i(axi_bkwd_valid_i), .axi_bkwd_resp_i(axi_bkwd_resp_i),
    .axi_bkwd_ready_o(axi_bkwd_ready_o)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;
  typedef struct packed {logic err; logic [7:0] lat;} d_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  d_t  d_q[$];

  int vec = 0, errs = 0, cyc = 0, acc_cyc = 0, done_cyc = -1, w_beats = 0, slv_mode = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vec++;
    errs++;
    $display("FAIL %s: got timeout/unexpected event required none", name);
  endtask

  // Reference: what one request must look like on the bus
  function automatic void model_push(input logic [31:0] addr, input logic [2:0] typ,
                                     input logic [3:0] strb, input logic [127:0] data,
                                     input logic [1:0] resp, input int lat);
    int  nb;
    aw_t e;
    nb     = (typ == 3'd3) ? BEATS : 1;
    e.addr = (typ == 3'd3) ? (addr & ~32'(LINE_BYTES - 1)) : addr;
    e.len  = 8'(nb - 1);
    e.size = (typ >= 3'd2) ? 3'd2 : typ;
    aw_q.push_back(e);
    for (int k = 0; k < nb; k++)
      w_q.push_back({data[k*32 +: 32], (typ == 3'd3) ? 4'hF : strb, k == nb - 1});
    d_q.push_back({resp != 2'b00, 8'(lat)});
  endfunction

  task automatic issue(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                       input logic [127:0] data, input logic [1:0] resp, input int lat);
    int n;
    model_push(addr, typ, strb, data, resp, lat);
    wb_addr_i  = addr;
    wb_type_i  = typ;
    wb_strb_i  = strb;
    wb_data_i  = data;
    wb_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wb_ready_o && n < 500);
    if (!wb_ready_o) fail("accept_timeout");
    @(posedge clock); #1;
    wb_valid_i      = 1'b0;
    wb_addr_i       = $urandom;
    wb_data_i       = {$urandom, $urandom, $urandom, $urandom};
    wb_strb_i       = 4'($urandom);
    wb_type_i       = 3'($urandom);
    axi_bkwd_resp_i = resp;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((d_q.size() != 0 || !wb_ready_o) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) fail("idle_timeout");
    @(posedge clock); #1;
  endtask

  // Slave model: 0 = zero-wait, 1 = AW stalled 3 cycles + W ready toggling, 2 = random
  initial begin : slave
    int aw_wait;
    aw_wait            = 0;
    axi_addr_w_ready_i = 1'b0;
    axi_w_ready_i      = 1'b0;
    axi_bkwd_valid_i   = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (slv_mode)
        0: begin
          axi_addr_w_ready_i = 1'b1;
          axi_w_ready_i      = 1'b1;
          axi_bkwd_valid_i   = axi_bkwd_ready_o;
        end
        1: begin
          aw_wait            = axi_addr_w_valid_o ? aw_wait + 1 : 0;
          axi_addr_w_ready_i = (aw_wait >= 4);
          axi_w_ready_i      = ~axi_w_ready_i;
          axi_bkwd_valid_i   = axi_bkwd_ready_o;
        end
        default: begin
          axi_addr_w_ready_i = 1'($urandom_range(0, 1));
          axi_w_ready_i      = 1'($urandom_range(0, 1));
          axi_bkwd_valid_i   = axi_bkwd_ready_o && ($urandom_range(0, 2) == 0);
        end
      endcase
    end
  end

  initial begin : monitor
    logic aw_st, w_st, done_prev;
    aw_t  aw_hold, ae;
    w_t   w_hold, we;
    d_t   de;
    aw_st = 1'b0; w_st = 1'b0; done_prev = 1'b0;
    aw_hold = '0; w_hold = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        aw_st = 1'b0; w_st = 1'b0; done_prev = 1'b0;
      end else begin
        if (done_prev) check("done_one_cycle", wb_done_o, 1'b0);
        if (wb_done_o) begin
          if (d_q.size() == 0) fail("unexpected_done");
          else begin
            de = d_q.pop_front();
            check("err", wb_err_o, de.err);
            check("ready_at_done", wb_ready_o, 1'b1);
            if (de.lat != 0) check("latency", cyc - acc_cyc, de.lat);
          end
          done_cyc = cyc;
        end
        if (wb_err_o) check("err_without_done", wb_done_o, 1'b1);
        done_prev = wb_done_o;
        if (wb_valid_i && wb_ready_o) acc_cyc = cyc;

        if (aw_st)
          check("aw_stable", {axi_addr_w_valid_o, axi_addr_w_addr_o, axi_addr_w_len_o, axi_addr_w_size_o},
                {1'b1, aw_hold});
        if (axi_addr_w_valid_o && axi_addr_w_ready_i) begin
          if (aw_q.size() == 0) fail("unexpected_aw");
          else begin
            ae = aw_q.pop_front();
            check("aw_addr", axi_addr_w_addr_o, ae.addr);
            check("aw_len", axi_addr_w_len_o, ae.len);
            check("aw_size", axi_addr_w_size_o, ae.size);
          end
        end
        aw_st   = axi_addr_w_valid_o && !axi_addr_w_ready_i;
        aw_hold = {axi_addr_w_addr_o, axi_addr_w_len_o, axi_addr_w_size_o};

        if (w_st)
          check("w_stable", {axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o}, {1'b1, w_hold});
        if (axi_w_valid_o) check("w_overlaps_aw", axi_addr_w_valid_o, 1'b0);
        if (axi_w_valid_o && axi_w_ready_i) begin
          w_beats++;
          if (w_q.size() == 0) fail("unexpected_w_beat");
          else begin
            we = w_q.pop_front();
            check("w_data", axi_w_data_o, we.data);
            check("w_strb", axi_w_strb_o, we.strb);
            check("w_last", axi_w_last_o, we.last);
          end
        end
        w_st   = axi_w_valid_o && !axi_w_ready_i;
        w_hold = {axi_w_data_o, axi_w_strb_o, axi_w_last_o};
      end
    end
  end

  initial begin : stimulus
    int n;
    reset = 1'b1;
    wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; wb_strb_i = '0; wb_type_i = '0;
    axi_bkwd_resp_i = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", wb_ready_o, 1'b1);
    check("rst_valids", {axi_addr_w_valid_o, axi_w_valid_o, axi_w_last_o, axi_bkwd_ready_o}, 4'b0);
    check("rst_done_err", {wb_done_o, wb_err_o}, 2'b0);
    check("rst_aw_fields", {axi_addr_w_addr_o, axi_addr_w_len_o, axi_addr_w_size_o}, 43'b0);
    check("rst_w_fields", {axi_w_data_o, axi_w_strb_o}, 36'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    slv_mode = 0;
    issue(32'h8000_0104, 3'd2, 4'hF, {96'hA5A5_0000_1111_2222_3333_4444, 32'hDEAD_BEEF}, 2'b00, 4);
    issue(32'h1000_0003, 3'd0, 4'b1000, {96'h5A5A_9999_8888_7777_6666_5555, 32'h1234_5678}, 2'b00, 4);
    issue(32'h8000_0037, 3'd3, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 2'b00, 7);

    wait_idle();
    slv_mode = 1;
    issue(32'h8000_1048, 3'd3, 4'h3, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 2'b00, 0);
    issue(32'h2000_0002, 3'd1, 4'b1100, {96'h0, 32'hBEEF_0000}, 2'b01, 0);

    wait_idle();
    slv_mode = 0;
    issue(32'h8000_0200, 3'd3, 4'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 2'b10, 7);
    issue(32'h3000_0010, 3'd6, 4'b0110, {96'h0, 32'h0BAD_F00D}, 2'b00, 4);
    check("b2b_accept_cycle", acc_cyc, done_cyc);

    wait_idle();
    w_beats = 0;
    issue(32'h8000_2000, 3'd3, 4'h0, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 2'b00, 0);
    n = 0;
    while (w_beats < 2 && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    if (w_beats < 2) fail("w_beat2_timeout");
    @(posedge clock); #1;
    reset = 1'b1;
    aw_q.delete(); w_q.delete(); d_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_valids", {axi_addr_w_valid_o, axi_w_valid_o, axi_bkwd_ready_o}, 3'b0);
    check("abort_ready", wb_ready_o, 1'b1);
    check("abort_no_done", wb_done_o, 1'b0);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    issue(32'h8000_3004, 3'd3, 4'h0, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 2'b00, 7);

    for (int i = 0; i < 40; i++) begin
      int         md;
      logic [2:0] typ;
      md = $urandom_range(0, 2);
      if (md != 0 || slv_mode != 0) wait_idle();
      slv_mode = md;
      typ = 3'($urandom);
      issue($urandom, typ, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
            2'($urandom), (md == 0) ? ((typ == 3'd3) ? 7 : 4) : 0);
    end

    wait_idle();
    check("aw_queue_drained", aw_q.size(), 0);
    check("w_queue_drained", w_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
